// File: rtl/uart_rx_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_rx_param
// Description : Parametrised oversampling UART receiver. Mid-bit sampling
//               from an external baud tick, glitch-rejecting start detector,
//               parity / framing / overrun reporting and a valid/ready
//               holding register towards the consumer.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_param #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dout,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int c_TICK_W = $clog2(OVERSAMPLE);
    localparam int c_BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [c_TICK_W-1:0] c_TICK_MID  = c_TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(OVERSAMPLE - 1);
    localparam logic [c_TICK_W-1:0] c_TICK_ONE  = c_TICK_W'(1);
    localparam logic [c_BIT_W-1:0]  c_BIT_LAST  = c_BIT_W'(DATA_BITS - 1);
    localparam logic [c_BIT_W-1:0]  c_BIT_ONE   = c_BIT_W'(1);
    localparam logic                c_STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic                c_PAR_ODD   = 1'(PARITY_ODD);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_PARITY = 3'd3;
    localparam logic [2:0] c_ST_STOP   = 3'd4;

    localparam logic [2:0] c_ST_AFTER_DATA = (PARITY_EN != 0) ? c_ST_PARITY : c_ST_STOP;

    logic                 r_rx_meta;
    logic                 r_rx_s;
    logic [2:0]           r_state;
    logic                 r_armed;
    logic [c_TICK_W-1:0]  r_tick_cnt;
    logic [c_BIT_W-1:0]   r_bit_cnt;
    logic                 r_stop_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_perr;
    logic                 r_ferr;

    logic [2:0]           w_state_nxt;
    logic                 w_armed_nxt;
    logic [c_TICK_W-1:0]  w_tick_nxt;
    logic [c_BIT_W-1:0]   w_bit_nxt;
    logic                 w_stop_nxt;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic                 w_perr_nxt;
    logic                 w_ferr_nxt;
    logic                 w_done;
    logic                 w_sample;

    logic [DATA_BITS-1:0] r_dout;
    logic                 r_valid;
    logic                 r_parity_err;
    logic                 r_frame_err;
    logic                 r_overrun;

    // Two-flop synchroniser for the asynchronous line; idles high out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // Receiver state and counters; all next values come from the block below.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_armed    <= 1'b0;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_shift    <= '0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_armed    <= w_armed_nxt;
            r_tick_cnt <= w_tick_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_stop_cnt <= w_stop_nxt;
            r_shift    <= w_shift_nxt;
            r_perr     <= w_perr_nxt;
            r_ferr     <= w_ferr_nxt;
        end
    end

    // Next-state logic: everything holds unless a baud tick arrives.
    always_comb begin
        w_state_nxt = r_state;
        w_armed_nxt = r_armed;
        w_tick_nxt  = r_tick_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_stop_nxt  = r_stop_cnt;
        w_shift_nxt = r_shift;
        w_perr_nxt  = r_perr;
        w_ferr_nxt  = r_ferr;
        w_done      = 1'b0;
        w_sample    = (r_tick_cnt == c_TICK_LAST);
        if (baud_tick) begin
            case (r_state)
                c_ST_IDLE: begin
                    // Only a high-to-low transition starts a frame, never a held-low line.
                    if (r_rx_s) begin
                        w_armed_nxt = 1'b1;
                    end else if (r_armed) begin
                        w_state_nxt = c_ST_START;
                        w_tick_nxt  = '0;
                    end
                end
                c_ST_START: begin
                    if (r_tick_cnt == c_TICK_MID) begin
                        if (r_rx_s) begin
                            w_state_nxt = c_ST_IDLE;
                        end else begin
                            w_state_nxt = c_ST_DATA;
                            w_tick_nxt  = '0;
                            w_bit_nxt   = '0;
                            w_perr_nxt  = 1'b0;
                            w_ferr_nxt  = 1'b0;
                        end
                    end else begin
                        w_tick_nxt = r_tick_cnt + c_TICK_ONE;
                    end
                end
                c_ST_DATA: begin
                    if (w_sample) begin
                        w_tick_nxt  = '0;
                        w_shift_nxt = {r_rx_s, r_shift[DATA_BITS-1:1]};
                        w_bit_nxt   = r_bit_cnt + c_BIT_ONE;
                        if (r_bit_cnt == c_BIT_LAST) begin
                            w_state_nxt = c_ST_AFTER_DATA;
                            w_stop_nxt  = 1'b0;
                        end
                    end else begin
                        w_tick_nxt = r_tick_cnt + c_TICK_ONE;
                    end
                end
                c_ST_PARITY: begin
                    if (w_sample) begin
                        w_tick_nxt  = '0;
                        w_perr_nxt  = ^r_shift ^ r_rx_s ^ c_PAR_ODD;
                        w_state_nxt = c_ST_STOP;
                        w_stop_nxt  = 1'b0;
                    end else begin
                        w_tick_nxt = r_tick_cnt + c_TICK_ONE;
                    end
                end
                c_ST_STOP: begin
                    if (w_sample) begin
                        w_tick_nxt = '0;
                        if (!r_rx_s) begin
                            w_ferr_nxt = 1'b1;
                        end
                        if (r_stop_cnt == c_STOP_LAST) begin
                            w_state_nxt = c_ST_IDLE;
                            w_armed_nxt = 1'b0;
                            w_done      = 1'b1;
                        end else begin
                            w_stop_nxt = 1'b1;
                        end
                    end else begin
                        w_tick_nxt = r_tick_cnt + c_TICK_ONE;
                    end
                end
                default: begin
                    w_state_nxt = c_ST_IDLE;
                end
            endcase
        end
    end

    // Holding register: load on completion unless an unconsumed word would be lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout       <= '0;
            r_valid      <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_done) begin
                if (!r_valid || ready) begin
                    r_dout       <= r_shift;
                    r_parity_err <= r_perr;
                    r_frame_err  <= w_ferr_nxt;
                    r_valid      <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign dout       = r_dout;
    assign valid      = r_valid;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;

endmodule
`default_nettype wire
